// File: rtl/mux_sel_sequencer_if.sv
// rtl/mux_sel_sequencer_if.sv - handshake and mux-drive bundle for the select sequencer
interface mux_sel_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] a;
  logic [2:0] sel;
  logic       sample;
  logic       busy;
  logic       done;

  // Upstream producer / bench side
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  a,
    input  sel,
    input  sample,
    input  busy,
    input  done
  );

  // Sequencer side
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output a,
    output sel,
    output sample,
    output busy,
    output done
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - steps an 8:1 mux select through a latched word, one hold window per bit
module mux_sel_sequencer #(
  parameter int HOLD = 4,
  parameter int DESC = 0
) (
  input logic               clk,
  input logic               rst,
  mux_sel_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // First and last select positions depend on the serialisation order.
  localparam logic [2:0] START       = (DESC != 0) ? 3'd7 : 3'd0;
  localparam logic [2:0] END         = (DESC != 0) ? 3'd0 : 3'd7;
  // Terminal count of the hold counter; HOLD=256 maps to 8'hFF.
  localparam logic [7:0] HOLD_M1     = 8'(HOLD - 1);
  // With a one-cycle window every RUN cycle is a sample cycle.
  localparam logic       HOLD_IS_ONE = (HOLD == 1);

  state_t     state;
  logic [7:0] hc;
  logic [7:0] a_q;
  logic [2:0] sel_q;
  logic       in_ready_q;
  logic       busy_q;
  logic       sample_q;
  logic       done_q;

  logic [7:0] hc_inc;
  logic [2:0] sel_step;

  // Next hold count and next select position along the chosen direction.
  assign hc_inc   = hc + 8'd1;
  assign sel_step = (DESC != 0) ? (sel_q - 3'd1) : (sel_q + 3'd1);

  // Sequencer FSM; every output is a register updated alongside the state so
  // that sample always mirrors (state==RUN && hc==HOLD-1) without any decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= 8'h00;
      hc         <= 8'd0;
      sel_q      <= START;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      sample_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_data;
            sel_q      <= START;
            hc         <= 8'd0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            sample_q   <= HOLD_IS_ONE;
          end
        end
        RUN: begin
          if (sample_q) begin
            if (sel_q != END) begin
              // Window finished on an inner bit: advance to the next bit.
              sel_q    <= sel_step;
              hc       <= 8'd0;
              sample_q <= HOLD_IS_ONE;
            end else begin
              // Eighth window finished: no wrap, sel parks on END.
              state    <= FIN;
              sample_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end else begin
            hc       <= hc_inc;
            sample_q <= (hc_inc == HOLD_M1);
          end
        end
        FIN: begin
          // One-cycle completion pulse; the word in a is kept until the next accept.
          state      <= IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          sample_q   <= 1'b0;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.a        = a_q;
  assign bus.sel      = sel_q;
  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.sample   = sample_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - randomized self-checking bench for two sequencer configurations
module tb_mux_sel_sequencer;

  logic clk;
  logic rst [2];
  logic       vld [2];
  logic [7:0] dat [2];

  logic       o_ready  [2];
  logic       o_busy   [2];
  logic       o_sample [2];
  logic       o_done   [2];
  logic [7:0] o_a      [2];
  logic [2:0] o_sel    [2];

  int checks;
  int errors;

  logic [7:0] got_bits;
  int         got_cnt;

  mux_sel_sequencer_if bus0 ();
  mux_sel_sequencer_if bus1 ();

  // dut0: HOLD=4, LSB first; dut1: HOLD=1, MSB first
  mux_sel_sequencer #(.HOLD(4), .DESC(0)) dut0 (.clk(clk), .rst(rst[0]), .bus(bus0.slave));
  mux_sel_sequencer #(.HOLD(1), .DESC(1)) dut1 (.clk(clk), .rst(rst[1]), .bus(bus1.slave));

  assign bus0.in_valid = vld[0];
  assign bus0.in_data  = dat[0];
  assign bus1.in_valid = vld[1];
  assign bus1.in_data  = dat[1];

  assign o_ready[0]  = bus0.in_ready;
  assign o_busy[0]   = bus0.busy;
  assign o_sample[0] = bus0.sample;
  assign o_done[0]   = bus0.done;
  assign o_a[0]      = bus0.a;
  assign o_sel[0]    = bus0.sel;
  assign o_ready[1]  = bus1.in_ready;
  assign o_busy[1]   = bus1.busy;
  assign o_sample[1] = bus1.sample;
  assign o_done[1]   = bus1.done;
  assign o_a[1]      = bus1.a;
  assign o_sel[1]    = bus1.sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hold_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [2:0] start_of(input int d);
    return (d == 0) ? 3'd0 : 3'd7;
  endfunction

  // Sends one word at the current negedge (DUT must be idle) and follows it
  // cycle by cycle against the reference timeline: the i-th window spans
  // cycles i*H+1 .. (i+1)*H, sampling at its last cycle, done at 8H+1, ready at 8H+2.
  task automatic run_word(input int d, input logic [7:0] w, input bit spam);
    int h;
    int n;
    int idx;
    int bitpos;
    logic [2:0] exp_sel;
    logic exp_sample, exp_done, exp_busy, exp_ready;
    logic obs_bit;
    h = hold_of(d);
    n = 8 * h;
    got_bits = 8'h00;
    got_cnt  = 0;
    checks++;
    if (o_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready dut%0d: got %b expected 1", d, o_ready[d]);
    end
    vld[d] = 1'b1;
    dat[d] = w;
    for (int t = 1; t <= n + 2; t++) begin
      @(negedge clk);
      if (spam) begin
        vld[d] = 1'b1;
        dat[d] = 8'h3C;
      end else begin
        vld[d] = 1'b0;
      end
      idx        = (t <= n) ? (t - 1) / h : 7;
      bitpos     = (d == 0) ? idx : 7 - idx;
      exp_sel    = 3'(bitpos);
      exp_sample = (t <= n) && (t % h == 0);
      exp_done   = (t == n + 1);
      exp_busy   = (t <= n + 1);
      exp_ready  = (t == n + 2);
      checks++;
      if (o_sel[d] !== exp_sel) begin
        errors++;
        $display("FAIL sel dut%0d t=%0d: got %0d expected %0d", d, t, o_sel[d], exp_sel);
      end
      checks++;
      if (o_sample[d] !== exp_sample) begin
        errors++;
        $display("FAIL sample dut%0d t=%0d: got %b expected %b", d, t, o_sample[d], exp_sample);
      end
      checks++;
      if (o_done[d] !== exp_done) begin
        errors++;
        $display("FAIL done dut%0d t=%0d: got %b expected %b", d, t, o_done[d], exp_done);
      end
      checks++;
      if (o_busy[d] !== exp_busy) begin
        errors++;
        $display("FAIL busy dut%0d t=%0d: got %b expected %b", d, t, o_busy[d], exp_busy);
      end
      checks++;
      if (o_ready[d] !== exp_ready) begin
        errors++;
        $display("FAIL in_ready dut%0d t=%0d: got %b expected %b", d, t, o_ready[d], exp_ready);
      end
      checks++;
      if (o_ready[d] === 1'b1 && o_busy[d] === 1'b1) begin
        errors++;
        $display("FAIL ready_while_busy dut%0d t=%0d: got ready=1 busy=1 expected not both", d, t);
      end
      checks++;
      if (o_a[d] !== w) begin
        errors++;
        $display("FAIL a_hold dut%0d t=%0d: got %h expected %h", d, t, o_a[d], w);
      end
      if (o_sample[d] === 1'b1 && got_cnt < 8) begin
        obs_bit = o_a[d][o_sel[d]];
        got_bits[got_cnt] = obs_bit;
        got_cnt++;
        checks++;
        if (obs_bit !== w[bitpos]) begin
          errors++;
          $display("FAIL sampled_bit dut%0d t=%0d: got %b expected %b", d, t, obs_bit, w[bitpos]);
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      vld[d] = 1'b1;
      dat[d] = 8'hFF;
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_a[d] !== 8'h00) begin
        errors++;
        $display("FAIL reset_a dut%0d: got %h expected 00", d, o_a[d]);
      end
      checks++;
      if (o_sel[d] !== start_of(d)) begin
        errors++;
        $display("FAIL reset_sel dut%0d: got %0d expected %0d", d, o_sel[d], start_of(d));
      end
      checks++;
      if ({o_ready[d], o_busy[d], o_sample[d], o_done[d]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_flags dut%0d: got %b expected 1000", d,
                 {o_ready[d], o_busy[d], o_sample[d], o_done[d]});
      end
      rst[d] = 1'b0;
      vld[d] = 1'b0;
    end
  endtask

  task automatic test_idle_hold();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({o_ready[d], o_busy[d], o_sample[d], o_done[d]} !== 4'b1000 || o_sel[d] !== start_of(d)) begin
          errors++;
          $display("FAIL idle_hold dut%0d c=%0d: got flags=%b sel=%0d expected 1000 sel=%0d", d, c,
                   {o_ready[d], o_busy[d], o_sample[d], o_done[d]}, o_sel[d], start_of(d));
        end
      end
    end
  endtask

  task automatic test_lsb_first();
    run_word(0, 8'hAF, 1'b0);
    checks++;
    if (got_cnt !== 8 || got_bits !== 8'b1010_1111) begin
      errors++;
      $display("FAIL lsb_pattern: got %0d bits %b expected 8 bits 10101111", got_cnt, got_bits);
    end
  endtask

  task automatic test_msb_first();
    run_word(1, 8'hAF, 1'b0);
    checks++;
    if (got_cnt !== 8 || got_bits !== 8'b1111_0101) begin
      errors++;
      $display("FAIL msb_pattern: got %0d bits %b expected 8 bits 11110101", got_cnt, got_bits);
    end
  endtask

  task automatic test_busy_handshake();
    bit seen;
    run_word(0, 8'hAF, 1'b1);
    @(negedge clk);
    vld[0] = 1'b0;
    checks++;
    if (o_a[0] !== 8'h3C || o_busy[0] !== 1'b1 || o_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL busy_accept: got a=%h busy=%b ready=%b expected a=3c busy=1 ready=0",
               o_a[0], o_busy[0], o_ready[0]);
    end
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = (o_ready[0] === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL busy_drain: got ready=%b expected 1 within 40 cycles", o_ready[0]);
    end
  endtask

  task automatic test_mid_reset();
    int cnt;
    cnt = 0;
    vld[0] = 1'b1;
    dat[0] = 8'hAF;
    for (int c = 0; c < 40 && cnt < 3; c++) begin
      @(negedge clk);
      vld[0] = 1'b0;
      if (o_sample[0] === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 3) begin
      errors++;
      $display("FAIL mid_reset_samples: got %0d expected 3", cnt);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    checks++;
    if (o_a[0] !== 8'h00 || o_sel[0] !== 3'd0 || o_ready[0] !== 1'b1 || o_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: got a=%h sel=%0d ready=%b busy=%b expected 00 0 1 0",
               o_a[0], o_sel[0], o_ready[0], o_busy[0]);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (o_done[0] !== 1'b0 || o_sample[0] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_quiet c=%0d: got done=%b sample=%b expected 0 0", c, o_done[0], o_sample[0]);
      end
    end
  endtask

  task automatic test_random();
    int d;
    for (int k = 0; k < 12; k++) begin
      d = k % 2;
      for (int g = $urandom_range(0, 3); g > 0; g--) @(negedge clk);
      run_word(d, 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    run_word(1, 8'($urandom), 1'b0);
    run_word(1, 8'($urandom), 1'b0);
    run_word(0, 8'($urandom), 1'b0);
    run_word(0, 8'($urandom), 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      vld[d] = 1'b0;
      dat[d] = 8'h00;
    end
    test_reset();
    test_idle_hold();
    test_lsb_first();
    test_msb_first();
    @(negedge clk);
    test_busy_handshake();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
